// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock-enable dividers. Each channel emits a one-cycle tick
// per period and a 50% square wave, with glitch-free divisor retuning through a shadow register.
module clk_div_bank #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 26,
    parameter int DIV_INIT = 50000000,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] pend
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] act_reg;
        logic [CNT_W-1:0] shd_reg;
        logic             tick_reg;
        logic             sq_reg;
        logic             pend_reg;
        logic             wr_hit;
        logic             halted;
        logic             wrap;

        // Out-of-range channel numbers never match any gi, so such writes fall away.
        assign wr_hit = wr_en && (wr_ch == CH_W'(gi));
        assign halted = (act_reg == '0);
        // ">=" rather than "==" lets a corrupted counter recover on the next enabled edge.
        assign wrap   = !halted && (cnt_reg >= act_reg - CNT_W'(1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg  <= '0;
                act_reg  <= CNT_W'(DIV_INIT);
                shd_reg  <= CNT_W'(DIV_INIT);
                tick_reg <= 1'b0;
                sq_reg   <= 1'b0;
                pend_reg <= 1'b0;
            end else begin
                if (wr_hit) begin
                    shd_reg <= wr_div;
                end

                if (sync_clr) begin
                    cnt_reg  <= '0;
                    sq_reg   <= 1'b0;
                    tick_reg <= 1'b0;
                    act_reg  <= wr_hit ? wr_div : shd_reg;
                    pend_reg <= 1'b0;
                end else if (!en) begin
                    tick_reg <= 1'b0;
                    if (wr_hit) begin
                        pend_reg <= 1'b1;
                    end
                end else if (halted || wrap) begin
                    // A write landing on this edge stays pending for the following activation.
                    cnt_reg  <= '0;
                    act_reg  <= shd_reg;
                    pend_reg <= wr_hit;
                    tick_reg <= wrap;
                    if (wrap) begin
                        sq_reg <= ~sq_reg;
                    end
                end else begin
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    tick_reg <= 1'b0;
                    if (wr_hit) begin
                        pend_reg <= 1'b1;
                    end
                end
            end
        end

        assign tick[gi] = tick_reg;
        assign sq[gi]   = sq_reg;
        assign pend[gi] = pend_reg;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: three channels, 8-bit counters, divisor 4 at reset.
module tb_clk_div_bank;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              sync_clr;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] pend;

    int checks   = 0;
    int failures = 0;

    clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .tick(tick), .sq(sq), .pend(pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        wr_en;
        logic [1:0]  wr_ch;
        logic [7:0]  wr_div;
        logic [2:0]  tick;
        logic [2:0]  sq;
        logic [2:0]  pend;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic e, input logic we, input logic [1:0] ch,
                                input logic [7:0] d, input logic [2:0] t,
                                input logic [2:0] s, input logic [2:0] p);
        vec_t v;
        v.en = e; v.wr_en = we; v.wr_ch = ch; v.wr_div = d;
        v.tick = t; v.sq = s; v.pend = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic we,
                        input logic [1:0] ch, input logic [7:0] d);
        en = e; sync_clr = c; wr_en = we; wr_ch = ch; wr_div = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;

        // Edge-by-edge expectations after reset release; bits are {ch2, ch1, ch0}.
        vq.push_back(mk(1, 0, 0, 0, 3'b000, 3'b000, 3'b000)); // E1
        vq.push_back(mk(1, 0, 0, 0, 3'b000, 3'b000, 3'b000)); // E2
        vq.push_back(mk(1, 0, 0, 0, 3'b000, 3'b000, 3'b000)); // E3
        vq.push_back(mk(1, 0, 0, 0, 3'b111, 3'b111, 3'b000)); // E4 first wrap
        vq.push_back(mk(1, 0, 0, 0, 3'b000, 3'b111, 3'b000)); // E5
        vq.push_back(mk(1, 1, 0, 2, 3'b000, 3'b111, 3'b001)); // E6 ch0 <- 2 at C=1
        vq.push_back(mk(1, 0, 0, 0, 3'b000, 3'b111, 3'b001)); // E7
        vq.push_back(mk(1, 0, 0, 0, 3'b111, 3'b000, 3'b000)); // E8 old period ends
        vq.push_back(mk(1, 0, 0, 0, 3'b000, 3'b000, 3'b000)); // E9
        vq.push_back(mk(1, 0, 0, 0, 3'b001, 3'b001, 3'b000)); // E10 ch0 period 2
        vq.push_back(mk(1, 0, 0, 0, 3'b000, 3'b001, 3'b000)); // E11
        vq.push_back(mk(1, 1, 1, 3, 3'b111, 3'b110, 3'b010)); // E12 write on ch1 wrap
        vq.push_back(mk(1, 1, 3, 1, 3'b000, 3'b110, 3'b010)); // E13 out-of-range write
        vq.push_back(mk(1, 0, 0, 0, 3'b001, 3'b111, 3'b010)); // E14
        vq.push_back(mk(1, 0, 0, 0, 3'b000, 3'b111, 3'b010)); // E15
        vq.push_back(mk(1, 0, 0, 0, 3'b111, 3'b000, 3'b000)); // E16 ch1 still period 4
        vq.push_back(mk(1, 0, 0, 0, 3'b000, 3'b000, 3'b000)); // E17
        vq.push_back(mk(1, 0, 0, 0, 3'b001, 3'b001, 3'b000)); // E18
        vq.push_back(mk(1, 0, 0, 0, 3'b010, 3'b011, 3'b000)); // E19 ch1 period 3
        vq.push_back(mk(1, 0, 0, 0, 3'b101, 3'b110, 3'b000)); // E20

        repeat (2) @(posedge clk);
        #1;
        chk("reset_tick", 8'(tick), 8'h0);
        chk("reset_sq",   8'(sq),   8'h0);
        chk("reset_pend", 8'(pend), 8'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].en, 1'b0, vq[i].wr_en, vq[i].wr_ch, vq[i].wr_div);
            chk($sformatf("vec%0d_tick", i + 1), 8'(tick), 8'(vq[i].tick));
            chk($sformatf("vec%0d_sq",   i + 1), 8'(sq),   8'(vq[i].sq));
            chk($sformatf("vec%0d_pend", i + 1), 8'(pend), 8'(vq[i].pend));
        end

        // Freeze with ch2 at C=2 (A=4); a write to ch0 during the freeze still registers.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, k == 0, 2'd0, 8'd5);
            chk($sformatf("frz%0d_tick", k), 8'(tick), 8'h0);
            chk($sformatf("frz%0d_sq", k),   8'(sq),   8'h5);
        end
        chk("frz_pend0", 8'(pend[0]), 8'h1);
        step(1, 0, 0, 0, 0);
        chk("unfrz1_tick2", 8'(tick[2]), 8'h0);
        step(1, 0, 0, 0, 0);
        chk("unfrz2_tick2", 8'(tick[2]), 8'h1);
        chk("unfrz2_sq2",   8'(sq[2]),   8'h0);

        // Realign with bypass write: A = {6, 3, 5}.
        step(1, 1, 1, 2'd2, 8'd6);
        chk("clr_sq",   8'(sq),   8'h0);
        chk("clr_tick", 8'(tick), 8'h0);
        chk("clr_pend", 8'(pend), 8'h0);
        for (int k = 1; k <= 6; k++) begin
            step(1, 0, 0, 0, 0);
            chk($sformatf("clr_k%0d_tick", k), 8'(tick),
                8'({k == 6, (k % 3) == 0, k == 5}));
        end

        // Halt ch1 with divisor 0, then restart at 3.
        step(1, 0, 1, 2'd1, 8'd0);
        chk("halt_wr_pend1", 8'(pend[1]), 8'h1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("halt_last_tick1", 8'(tick[1]), 8'h1);
        chk("halt_last_sq1",   8'(sq[1]),   8'h1);
        chk("halt_last_pend1", 8'(pend[1]), 8'h0);
        for (int k = 0; k < 100; k++) begin
            step(1, 0, 0, 0, 0);
            chk($sformatf("halt%0d_tick1", k), 8'(tick[1]), 8'h0);
            chk($sformatf("halt%0d_sq1", k),   8'(sq[1]),   8'h1);
        end
        step(0, 0, 1, 2'd1, 8'd3);
        chk("restart_pend1", 8'(pend[1]), 8'h1);
        step(1, 0, 0, 0, 0);
        chk("restart_act_pend1", 8'(pend[1]), 8'h0);
        chk("restart_act_tick1", 8'(tick[1]), 8'h0);
        for (int k = 1; k <= 6; k++) begin
            step(1, 0, 0, 0, 0);
            chk($sformatf("restart_k%0d_tick1", k), 8'(tick[1]), 8'((k % 3) == 0));
        end

        // Asynchronous reset mid-period with a pending write.
        step(1, 0, 1, 2'd0, 8'd7);
        chk("rst_pre_pend0", 8'(pend[0]), 8'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tick", 8'(tick), 8'h0);
        chk("rst_async_sq",   8'(sq),   8'h0);
        chk("rst_async_pend", 8'(pend), 8'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, k == 1, 2'd3, 8'd1);
            chk($sformatf("post_rst_k%0d_tick", k), 8'(tick), 8'({3{(k % 4) == 0}}));
            chk($sformatf("post_rst_k%0d_sq", k),   8'(sq),   8'({3{k >= 4 && k < 8}}));
            chk($sformatf("post_rst_k%0d_pend", k), 8'(pend), 8'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
